// File: rtl/main_mem_arbiter.sv
// main_mem_arbiter: round-robin arbiter sharing the single-port main_memory between two line requesters.
// Optional MEM_ARB_STATS_EN adds saturating per-port grant counters (m0_gnt_cnt / m1_gnt_cnt).

module main_mem_arbiter #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]       m0_gnt_cnt,
  output logic [15:0]       m1_gnt_cnt
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;

  localparam logic [2:0] WAIT_INIT = 3'(RD_LAT - 1);

  state_e            state_q;
  logic              last_q, win_q, we_q;
  logic [2:0]        cnt_q;
  logic              gnt0_q, gnt1_q, rv0_q, rv1_q, wren_q;
  logic [ADDR_W-1:0] maddr_q;
  logic [DATA_W-1:0] mdata_q, rd0_q, rd1_q;

  logic              pick_vld, pick_d, pick_we_d;
  logic [ADDR_W-1:0] pick_addr_d;
  logic [DATA_W-1:0] pick_wdata_d;

  // Tie goes to the port that did not win last; a lone requester always wins.
  always_comb begin
    pick_vld     = m0_req | m1_req;
    pick_d       = (m0_req && m1_req) ? ~last_q : m1_req;
    pick_we_d    = pick_d ? m1_we    : m0_we;
    pick_addr_d  = pick_d ? m1_addr  : m0_addr;
    pick_wdata_d = pick_d ? m1_wdata : m0_wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      wren_q  <= 1'b0;
      maddr_q <= '0;
      mdata_q <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            state_q <= ST_ISSUE;
            last_q  <= pick_d;
            win_q   <= pick_d;
            we_q    <= pick_we_d;
            maddr_q <= pick_addr_d;
            mdata_q <= pick_wdata_d;
            wren_q  <= pick_we_d;
            gnt0_q  <= ~pick_d;
            gnt1_q  <= pick_d;
          end
        end
        ST_ISSUE: begin
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          wren_q  <= 1'b0;
          cnt_q   <= WAIT_INIT;
          state_q <= we_q ? ST_IDLE : ST_WAIT;
        end
        ST_WAIT: begin
          // mem_q is valid in the last WAIT cycle; capture and raise rvalid together.
          if (cnt_q == '0) begin
            state_q <= ST_RESP;
            if (win_q) begin
              rd1_q <= mem_q;
              rv1_q <= 1'b1;
            end else begin
              rd0_q <= mem_q;
              rv0_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ST_RESP: begin
          rv0_q   <= 1'b0;
          rv1_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m0_gnt    = gnt0_q;
  assign m1_gnt    = gnt1_q;
  assign m0_rvalid = rv0_q;
  assign m1_rvalid = rv1_q;
  assign m0_rdata  = rd0_q;
  assign m1_rdata  = rd1_q;
  assign mem_addr  = maddr_q;
  assign mem_data  = mdata_q;
  assign mem_wren  = wren_q;

`ifdef MEM_ARB_STATS_EN
  logic        issue0, issue1;
  logic [15:0] gcnt0_q, gcnt1_q;

  always_comb begin
    issue0 = (state_q == ST_IDLE) && pick_vld && !pick_d;
    issue1 = (state_q == ST_IDLE) && pick_vld &&  pick_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
    end else begin
      if (issue0 && (gcnt0_q != '1)) gcnt0_q <= gcnt0_q + 16'd1;
      if (issue1 && (gcnt1_q != '1)) gcnt1_q <= gcnt1_q + 16'd1;
    end
  end

  assign m0_gnt_cnt = gcnt0_q;
  assign m1_gnt_cnt = gcnt1_q;
`endif

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Self-checking bench for main_mem_arbiter: directed table, multi-cycle corner sequences,
// and randomized traffic against a transaction-level timing/memory model.

module tb_main_mem_arbiter;
  localparam int AW = 14;
  localparam int DW = 128;
  localparam int RL = 2;
  localparam int NR = 1500;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_wren;
  logic [DW-1:0] m0_rdata, m1_rdata, mem_data, mem_q;
  logic [AW-1:0] mem_addr;
`ifdef MEM_ARB_STATS_EN
  logic [15:0]   m0_gnt_cnt, m1_gnt_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  main_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
`ifdef MEM_ARB_STATS_EN
    , .m0_gnt_cnt(m0_gnt_cnt), .m1_gnt_cnt(m1_gnt_cnt)
`endif
  );

  // Behavioural main_memory: RL-cycle registered read pipeline plus a backdoor preload.
  bit [DW-1:0]   env_mem [16384];
  bit [DW-1:0]   pipe [RL];
  logic          bk_we = 1'b0;
  logic [AW-1:0] bk_addr = '0;
  logic [DW-1:0] bk_data = '0;

  assign mem_q = pipe[RL-1];

  always @(posedge clock) begin
    if (bk_we) env_mem[bk_addr] <= bk_data;
    else if (mem_wren) env_mem[mem_addr] <= mem_data;
    pipe[0] <= env_mem[mem_addr];
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end

  typedef struct {
    bit            port;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0b exp=%0b", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit p, input logic r, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    if (p) begin
      m1_req = r; m1_we = we; m1_addr = a; m1_wdata = d;
    end else begin
      m0_req = r; m0_we = we; m0_addr = a; m0_wdata = d;
    end
  endtask

  function automatic logic gnt_of(input bit p);
    return p ? m1_gnt : m0_gnt;
  endfunction

  function automatic logic rv_of(input bit p);
    return p ? m1_rvalid : m0_rvalid;
  endfunction

  function automatic logic [DW-1:0] rd_of(input bit p);
    return p ? m1_rdata : m0_rdata;
  endfunction

  task automatic check_all_zero(input string nm);
    chkb({nm, "_gnt0"}, m0_gnt, 1'b0);
    chkb({nm, "_gnt1"}, m1_gnt, 1'b0);
    chkb({nm, "_rv0"}, m0_rvalid, 1'b0);
    chkb({nm, "_rv1"}, m1_rvalid, 1'b0);
    chkb({nm, "_wren"}, mem_wren, 1'b0);
    chk({nm, "_maddr"}, 128'(mem_addr), '0);
    chk({nm, "_mdata"}, mem_data, '0);
    chk({nm, "_rd0"}, m0_rdata, '0);
    chk({nm, "_rd1"}, m1_rdata, '0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    #2 reset = 1'b0;
    #1;
    repeat (2) @(posedge clock);
    #3 reset = 1'b1;
  endtask

  // One transaction from an idle arbiter: latency, memory-side values, read data, isolation.
  task automatic run_txn(input string nm, input vec_t v);
    logic [DW-1:0] other_rd;
    bit            found;
    int            lat;
    tick();
    other_rd = rd_of(!v.port);
    drive(v.port, 1'b1, v.we, v.addr, v.wdata);
    found = 0;
    lat   = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (gnt_of(v.port)) begin
        found = 1;
        lat   = k;
        break;
      end
    end
    chkb({nm, "_gnt_seen"}, found, 1'b1);
    if (!found) begin
      drive(v.port, 1'b0, 1'b0, '0, '0);
      return;
    end
    chki({nm, "_gnt_lat"}, lat, 1);
    chkb({nm, "_other_gnt"}, gnt_of(!v.port), 1'b0);
    chkb({nm, "_wren"}, mem_wren, v.we);
    chk({nm, "_maddr"}, 128'(mem_addr), 128'(v.addr));
    if (v.we) chk({nm, "_mdata"}, mem_data, v.wdata);
    tick();
    drive(v.port, 1'b0, 1'b0, '0, '0);
    chkb({nm, "_wren_off"}, mem_wren, 1'b0);
    chkb({nm, "_gnt_pulse"}, gnt_of(v.port), 1'b0);
    if (!v.we) begin
      found = 0;
      for (int j = 1; j <= 16; j++) begin
        if (j > 1) tick();
        if (rv_of(v.port)) begin
          found = 1;
          lat   = j;
          break;
        end
      end
      chkb({nm, "_rv_seen"}, found, 1'b1);
      chki({nm, "_rv_lat"}, lat, RL + 1);
      chk({nm, "_rdata"}, rd_of(v.port), v.exp_rdata);
      chkb({nm, "_other_rv"}, rv_of(!v.port), 1'b0);
      tick();
      chkb({nm, "_rv_pulse"}, rv_of(v.port), 1'b0);
    end
    chk({nm, "_other_rd"}, rd_of(!v.port), other_rd);
  endtask

  function automatic logic [DW-1:0] b2b_data(input int n);
    return {4{32'hC0DE_0000 | 32'(n)}};
  endfunction

  // Randomized-phase reference: per-cycle expectations derived from transaction timing rules.
  bit            eg0 [NR+16];
  bit            eg1 [NR+16];
  bit            erv0 [NR+16];
  bit            erv1 [NR+16];
  bit            ewr [NR+16];
  logic [AW-1:0] ema [NR+16];
  logic [DW-1:0] emd [NR+16];
  logic [DW-1:0] erd [NR+16];
  bit   [DW-1:0] mm [8];

  initial begin
    int            gp [4];
    int            gc [4];
    int            ng, nboth, nw, lastk, nrv, free_at;
    bit            pend, w, last;
    bit            act [2];
    bit            rwe [2];
    logic [AW-1:0] raddr [2];
    logic [DW-1:0] rwd [2];
    logic [AW-1:0] cur_ma;
    logic [DW-1:0] cur_md, cur_rd0, cur_rd1;
    vec_t          v;

    vt[0] = '{1'b0, 1'b0, 14'h0010, '0, {16{8'hA5}}};
    vt[1] = '{1'b1, 1'b1, 14'h3FFF, 128'h1234, '0};
    vt[2] = '{1'b1, 1'b0, 14'h3FFF, '0, 128'h1234};
    vt[3] = '{1'b0, 1'b1, 14'h0020, {4{32'hDEAD_BEEF}}, '0};
    vt[4] = '{1'b1, 1'b0, 14'h0020, '0, {4{32'hDEAD_BEEF}}};
    vt[5] = '{1'b0, 1'b0, 14'h3FFF, '0, 128'h1234};

    // Reset state, with a real falling edge on reset.
    #2 reset = 1'b0;
    #1;
    check_all_zero("reset");
    @(posedge clock);
    #1;
    bk_we = 1'b1; bk_addr = 14'h0010; bk_data = {16{8'hA5}};
    @(posedge clock);
    #1;
    bk_we = 1'b0;
    @(posedge clock);
    #3 reset = 1'b1;

    // Contention out of reset: port 0 first, then strict alternation while both hold.
    tick();
    drive(1'b0, 1'b1, 1'b0, 14'h0010, '0);
    drive(1'b1, 1'b1, 1'b0, 14'h0010, '0);
    ng = 0;
    nboth = 0;
    for (int k = 1; k <= 4 * (RL + 3) + 6; k++) begin
      tick();
      if (m0_gnt && m1_gnt) nboth++;
      if ((m0_gnt || m1_gnt) && ng < 4) begin
        gp[ng] = int'(m1_gnt);
        gc[ng] = k;
        ng++;
      end
      if (ng == 4) break;
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    chki("cont_ngrants", ng, 4);
    chki("cont_both", nboth, 0);
    chki("cont_first_lat", gc[0], 1);
    for (int i = 0; i < 4; i++) chki($sformatf("cont_port%0d", i), gp[i], i % 2);
    for (int i = 1; i < 4; i++) chki($sformatf("cont_gap%0d", i), gc[i] - gc[i-1], RL + 3);
    repeat (RL + 3) tick();

    // Directed single-transaction table.
    for (int i = 0; i < 6; i++) run_txn($sformatf("vec%0d", i), vt[i]);

    // Back-to-back writes from port 0 with a held request.
    tick();
    drive(1'b0, 1'b1, 1'b1, 14'h0200, b2b_data(0));
    ng = 0; nw = 0; lastk = 0; pend = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (pend) begin
        pend = 0;
        if (ng < 8) drive(1'b0, 1'b1, 1'b1, 14'h0200 + 14'(ng), b2b_data(ng));
        else drive(1'b0, 1'b0, 1'b0, '0, '0);
      end
      if (mem_wren) nw++;
      if (m0_gnt) begin
        chk($sformatf("b2b_addr%0d", ng), 128'(mem_addr), 128'(14'h0200 + 14'(ng)));
        chk($sformatf("b2b_data%0d", ng), mem_data, b2b_data(ng));
        if (ng > 0) chki($sformatf("b2b_gap%0d", ng), k - lastk, 2);
        else chki("b2b_first_lat", k, 1);
        lastk = k;
        ng++;
        pend = 1;
      end
      if (ng == 8 && !pend) break;
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    chki("b2b_ngnt", ng, 8);
    chki("b2b_nwren", nw, 8);
    v = '{1'b1, 1'b0, 14'h0207, '0, b2b_data(7)};
    run_txn("b2b_readback", v);

    // Reset asserted while an m1 read is waiting on memory.
    do_reset();
    tick();
    drive(1'b1, 1'b1, 1'b0, 14'h0010, '0);
    tick();
    chkb("rstw_gnt", m1_gnt, 1'b1);
    tick();
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    #2 reset = 1'b0;
    #1;
    check_all_zero("rstw");
    repeat (2) @(posedge clock);
    #3 reset = 1'b1;
    nrv = 0;
    for (int k = 0; k < RL + 5; k++) begin
      tick();
      if (m1_rvalid || m0_rvalid) nrv++;
    end
    chki("rstw_no_rvalid", nrv, 0);
    v = '{1'b1, 1'b0, 14'h0020, '0, {4{32'hDEAD_BEEF}}};
    run_txn("rstw_after", v);

`ifdef MEM_ARB_STATS_EN
    do_reset();
    for (int i = 0; i < 5; i++) begin
      v = '{(i >= 3), 1'b1, 14'h0300 + 14'(i), 128'(i), '0};
      run_txn($sformatf("stat%0d", i), v);
    end
    chki("stat_cnt0", int'(m0_gnt_cnt), 3);
    chki("stat_cnt1", int'(m1_gnt_cnt), 2);
    do_reset();
    chki("stat_rst0", int'(m0_gnt_cnt), 0);
    chki("stat_rst1", int'(m1_gnt_cnt), 0);
`endif

    // Randomized traffic on 0x100..0x107 against the transaction-timing model.
    do_reset();
    free_at = 0;
    last    = 1'b1;
    cur_ma  = '0;
    cur_md  = '0;
    cur_rd0 = '0;
    cur_rd1 = '0;
    for (int p = 0; p < 2; p++) begin
      act[p] = 0; rwe[p] = 0; raddr[p] = '0; rwd[p] = '0;
    end
    for (int c = 0; c < NR; c++) begin
      tick();
      if (eg0[c] || eg1[c]) begin
        cur_ma = ema[c];
        cur_md = emd[c];
      end
      if (erv0[c]) cur_rd0 = erd[c];
      if (erv1[c]) cur_rd1 = erd[c];
      chkb("rnd_gnt0", m0_gnt, eg0[c]);
      chkb("rnd_gnt1", m1_gnt, eg1[c]);
      chkb("rnd_rv0", m0_rvalid, erv0[c]);
      chkb("rnd_rv1", m1_rvalid, erv1[c]);
      chkb("rnd_wren", mem_wren, ewr[c]);
      chk("rnd_maddr", 128'(mem_addr), 128'(cur_ma));
      chk("rnd_mdata", mem_data, cur_md);
      chk("rnd_rd0", m0_rdata, cur_rd0);
      chk("rnd_rd1", m1_rdata, cur_rd1);
      for (int p = 0; p < 2; p++) begin
        if (c > 0 && (p == 0 ? eg0[c-1] : eg1[c-1])) act[p] = 0;
        if (!act[p] && $urandom_range(0, 99) < 45) begin
          act[p]   = 1;
          rwe[p]   = 1'($urandom_range(0, 1));
          raddr[p] = 14'h0100 + 14'($urandom_range(0, 7));
          rwd[p]   = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      drive(1'b0, act[0], rwe[0], raddr[0], rwd[0]);
      drive(1'b1, act[1], rwe[1], raddr[1], rwd[1]);
      if (c >= free_at && (act[0] || act[1])) begin
        w    = (act[0] && act[1]) ? !last : act[1];
        last = w;
        if (w) eg1[c+1] = 1; else eg0[c+1] = 1;
        ema[c+1] = raddr[w];
        emd[c+1] = rwd[w];
        if (rwe[w]) begin
          ewr[c+1] = 1;
          mm[raddr[w][2:0]] = rwd[w];
          free_at = c + 2;
        end else begin
          if (w) erv1[c+RL+2] = 1; else erv0[c+RL+2] = 1;
          erd[c+RL+2] = mm[raddr[w][2:0]];
          free_at = c + RL + 3;
        end
      end
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (RL + 4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog act=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
